sprite_bounce_ctrl: RTL and testbench
=====================================

# sprite_bounce_ctrl

Sprite motion sequencer that sits directly upstream of `vgamult` and drives its sprite-control inputs (`x`, `y`, `visable`, `load_pos`, `load_att`, `sprite_sel`) in place of the fixed timer-based controller. Once per N display frames it advances one sprite by a fixed step and reflects it off the screen edges. Each move produces a one-cycle `load_pos` pulse. Each bounce toggles the sprite image and produces a one-cycle `load_att` pulse.

## Interface
Parameters:
- `H_MAX`, 640: visible width in pixels.
- `V_MAX`, 480: visible height in pixels.
- `SPR_W`, 32: sprite width; must be even.
- `SPR_H`, 32: sprite height; must be even.
- `STEP`, 2: pixels moved per update on each axis; must be even and ≥2.
- `FRAME_DIV`, 1: number of frame ticks per update (≥1).
- `X0`, 0: reset x position; must be even.
- `Y0`, 0: reset y position; must be even.

Ports:
- `clk`  in  1  system clock, the `clk` produced by `vgamult`. One clock, synchronous design.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  when low, frame ticks are ignored and all registers hold.
- `frame_tick`  in  1  one-cycle pulse per frame, derived from the vsync edge.
- `x`  out  10  sprite left edge; bit 0 always 0.
- `y`  out  9  sprite top edge; bit 0 always 0.
- `visable`  out  1  sprite-visible attribute.
- `load_pos`  out  1  one-cycle strobe; `x`/`y` are valid in the same cycle.
- `load_att`  out  1  one-cycle strobe; `sprite_sel`/`visable` are valid in the same cycle.
- `sprite_sel`  out  5  sprite image index.
- `busy`  out  1  high in every state except WAIT.

## Operation
- Reset values:
  - `x=X0`, `y=Y0`.
  - Direction bits `dx=+`, `dy=+`.
  - `visable=0`, `sprite_sel=5'b00010`.
  - `load_pos=0`, `load_att=0`.
  - Frame counter = 0.
  - State INIT.
- States and transitions:
  - INIT: set `visable=1`; pulse `load_pos` and `load_att` together in one cycle; go to WAIT.
  - WAIT: on `frame_tick && enable`, increment the frame counter.
    - If the counter was `FRAME_DIV-1`, clear it and go to MOVE.
    - `frame_tick` in any other state is dropped, not queued.
  - MOVE (1 cycle): compute the next x/y and direction bits, and latch a `bounce` flag; go to LOAD_POS.
  - LOAD_POS: `load_pos=1`.
    - If `bounce`: go to LOAD_ATT.
    - Otherwise: go to WAIT.
  - LOAD_ATT: `load_att=1`; `sprite_sel` takes `{sprite_sel[4:1], ~sprite_sel[0]}` in this same cycle; go to WAIT.
- Axis arithmetic (x shown; y is identical with `V_MAX`/`SPR_H`). Let `XLIM = H_MAX-SPR_W`.
  - Moving `+`, `x+STEP >= XLIM`: x becomes XLIM, dx becomes `-`, `bounce=1`.
  - Moving `+` otherwise: x becomes x+STEP.
  - Moving `-`, `x <= STEP`: x becomes 0, dx becomes `+`, `bounce=1`.
  - Moving `-` otherwise: x becomes x−STEP.
  - Compute in 11/10-bit intermediates so nothing wraps.
- Corner hit (both axes bounce in the same MOVE): a single `load_att`, and `sprite_sel[0]` toggles once.
- `enable` low in MOVE, LOAD_POS or LOAD_ATT: the in-flight sequence still completes; only WAIT is gated.
- `rst` mid-sequence: all registers return to reset values on the next edge and any pending `load_att` is discarded.

## Timing
- `frame_tick` in cycle T (with the counter about to wrap):
  - MOVE at T+1.
  - `load_pos` high at T+2, with the new x/y.
  - `load_att` high at T+3 if there was a bounce.
  - Back in WAIT at T+3 (no bounce) or T+4 (bounce).
- `load_pos` and `load_att` are never high in the same cycle, except the INIT cycle.
- x/y change only on the edge entering LOAD_POS; they are stable at all other times.
- The first INIT strobe occurs in the first cycle after `rst` deasserts.
- Minimum frame-tick spacing for lossless operation: 4 cycles.

## Structure
- Shared package `vga_pkg` holds:
  - `H_MAX`, `V_MAX` defaults.
  - State encoding: INIT=0, WAIT=1, MOVE=2, LOAD_POS=3, LOAD_ATT=4, on 3 bits.
  - The reset `sprite_sel` constant `5'b00010`.
- One sub-module, `bounce_axis`, instantiated once for x and once for y. It is parameterised on LIM, STEP and width, with inputs pos/dir and outputs next_pos/next_dir/bounce.

## Test plan
- Reset, then idle 3 cycles → INIT cycle shows `load_pos=1`, `load_att=1`, `visable=1`, `sprite_sel=00010`, `x=0`, `y=0`; then all strobes stay 0.
- From x=0, y=0, one `frame_tick` → `load_pos` exactly 2 cycles later with x=2, y=2; no `load_att`.
- With X0=606, dx=+ (XLIM=608), one tick → x=608, dx becomes `-`, `load_att` one cycle after `load_pos`, `sprite_sel=00011`.
- With X0=608, Y0=448, both dirs `+` → corner hit: x=608, y=448, both dirs flip, exactly one `load_att`, `sprite_sel=00011`.
- FRAME_DIV=3 with 6 ticks → exactly 2 `load_pos` pulses; a tick issued in MOVE is dropped; with `enable=0` ticks produce no strobes.
- Assert `rst` in the LOAD_POS cycle of a bouncing move → no `load_att`, outputs return to reset values, and INIT replays.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA sprite path.
//   H_MAX_DEF / V_MAX_DEF : default visible resolution
//   state_e               : sprite_bounce_ctrl FSM encoding (3 bits)
//   SPRITE_SEL_RST        : sprite image index loaded at reset
package vga_pkg;

  localparam int H_MAX_DEF = 640;
  localparam int V_MAX_DEF = 480;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_WAIT     = 3'd1,
    S_MOVE     = 3'd2,
    S_LOAD_POS = 3'd3,
    S_LOAD_ATT = 3'd4
  } state_e;

  localparam logic [4:0] SPRITE_SEL_RST = 5'b00010;

endpackage

// File: rtl/bounce_axis.sv
// bounce_axis: one-axis step-and-reflect arithmetic (purely combinational).
//   pos      in  W  current edge position
//   dir      in  1  0 = moving +, 1 = moving -
//   next_pos out W  position after one step, clamped to [0, LIM]
//   next_dir out 1  direction after the step (flipped on a bounce)
//   bounce   out 1  an edge was reached this step
module bounce_axis #(
  parameter int W    = 10,
  parameter int LIM  = 608,
  parameter int STEP = 2
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  output logic [W-1:0] next_pos,
  output logic         next_dir,
  output logic         bounce
);

  // One extra bit so pos+STEP can never wrap before the limit compare.
  localparam logic [W:0] LIM_E  = (W+1)'(LIM);
  localparam logic [W:0] STEP_E = (W+1)'(STEP);

  logic [W:0] sum;
  assign sum = {1'b0, pos} + STEP_E;

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    bounce   = 1'b0;
    if (!dir) begin
      if (sum >= LIM_E) begin
        next_pos = LIM_E[W-1:0];
        next_dir = 1'b1;
        bounce   = 1'b1;
      end else begin
        next_pos = sum[W-1:0];
      end
    end else begin
      if ({1'b0, pos} <= STEP_E) begin
        next_pos = '0;
        next_dir = 1'b0;
        bounce   = 1'b1;
      end else begin
        next_pos = pos - STEP_E[W-1:0];
      end
    end
  end

endmodule

// File: rtl/sprite_bounce_ctrl.sv
// sprite_bounce_ctrl: moves one sprite every FRAME_DIV frames and reflects it
// off the screen edges, driving vgamult's sprite-control inputs.
//   clk, rst     clock and synchronous active-high reset
//   enable       gates frame ticks in WAIT; in-flight moves always finish
//   frame_tick   one-cycle pulse per frame
//   x, y         sprite top-left corner (even), valid with load_pos
//   visable      sprite-visible attribute
//   load_pos     one-cycle strobe: x/y valid
//   load_att     one-cycle strobe: sprite_sel/visable valid
//   sprite_sel   sprite image index, bit 0 toggles on every bounce
//   busy         high whenever the FSM is not in WAIT
module sprite_bounce_ctrl
  import vga_pkg::*;
#(
  parameter int H_MAX     = H_MAX_DEF,
  parameter int V_MAX     = V_MAX_DEF,
  parameter int SPR_W     = 32,
  parameter int SPR_H     = 32,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1,
  parameter int X0        = 0,
  parameter int Y0        = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       visable,
  output logic       load_pos,
  output logic       load_att,
  output logic [4:0] sprite_sel,
  output logic       busy
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  state_e        state_q, state_d;
  logic [9:0]    x_q, x_d, nx;
  logic [8:0]    y_q, y_d, ny;
  logic          dx_q, dx_d, ndx, bx;
  logic          dy_q, dy_d, ndy, by;
  logic          vis_q, vis_d;
  logic [4:0]    sel_q, sel_d;
  logic          lp_q, lp_d, la_q, la_d;
  logic          bounce_q, bounce_d;
  logic [CW-1:0] cnt_q, cnt_d;

  bounce_axis #(.W(10), .LIM(H_MAX - SPR_W), .STEP(STEP)) u_ax_x (
    .pos(x_q), .dir(dx_q), .next_pos(nx), .next_dir(ndx), .bounce(bx)
  );

  bounce_axis #(.W(9), .LIM(V_MAX - SPR_H), .STEP(STEP)) u_ax_y (
    .pos(y_q), .dir(dy_q), .next_pos(ny), .next_dir(ndy), .bounce(by)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    vis_d    = vis_q;
    sel_d    = sel_q;
    bounce_d = bounce_q;
    cnt_d    = cnt_q;
    lp_d     = 1'b0;
    la_d     = 1'b0;
    case (state_q)
      S_INIT: begin
        vis_d   = 1'b1;
        lp_d    = 1'b1;
        la_d    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (frame_tick && enable) begin
          if (cnt_q == CW'(FRAME_DIV - 1)) begin
            cnt_d   = '0;
            state_d = S_MOVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_MOVE: begin
        // Strobes are registered, so the new position and load_pos
        // both appear in the LOAD_POS cycle.
        x_d      = nx;
        y_d      = ny;
        dx_d     = ndx;
        dy_d     = ndy;
        bounce_d = bx | by;   // a corner hit still costs one attribute load
        lp_d     = 1'b1;
        state_d  = S_LOAD_POS;
      end
      S_LOAD_POS: begin
        if (bounce_q) begin
          la_d    = 1'b1;
          sel_d   = {sel_q[4:1], ~sel_q[0]};
          state_d = S_LOAD_ATT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_LOAD_ATT: state_d = S_WAIT;
      default:    state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      x_q      <= 10'(X0);
      y_q      <= 9'(Y0);
      dx_q     <= 1'b0;
      dy_q     <= 1'b0;
      vis_q    <= 1'b0;
      sel_q    <= SPRITE_SEL_RST;
      lp_q     <= 1'b0;
      la_q     <= 1'b0;
      bounce_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      vis_q    <= vis_d;
      sel_q    <= sel_d;
      lp_q     <= lp_d;
      la_q     <= la_d;
      bounce_q <= bounce_d;
      cnt_q    <= cnt_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign visable    = vis_q;
  assign load_pos   = lp_q;
  assign load_att   = la_q;
  assign sprite_sel = sel_q;
  assign busy       = (state_q != S_WAIT);

endmodule

// File: tb/tb_sprite_bounce_ctrl.sv
// Four instances share clk/rst/enable/frame_tick:
//   d0 defaults, d1 X0=606, d2 X0=608/Y0=448 (corner), d3 FRAME_DIV=3.
module tb_sprite_bounce_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, frame_tick;
  logic [9:0] xo  [4];
  logic [8:0] yo  [4];
  logic       vis [4];
  logic       lp  [4];
  logic       la  [4];
  logic [4:0] sel [4];
  logic       bsy [4];

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  sprite_bounce_ctrl d0 (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .x(xo[0]), .y(yo[0]), .visable(vis[0]), .load_pos(lp[0]),
    .load_att(la[0]), .sprite_sel(sel[0]), .busy(bsy[0]));

  sprite_bounce_ctrl #(.X0(606)) d1 (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .x(xo[1]), .y(yo[1]), .visable(vis[1]), .load_pos(lp[1]),
    .load_att(la[1]), .sprite_sel(sel[1]), .busy(bsy[1]));

  sprite_bounce_ctrl #(.X0(608), .Y0(448)) d2 (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .x(xo[2]), .y(yo[2]), .visable(vis[2]), .load_pos(lp[2]),
    .load_att(la[2]), .sprite_sel(sel[2]), .busy(bsy[2]));

  sprite_bounce_ctrl #(.FRAME_DIV(3)) d3 (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .x(xo[3]), .y(yo[3]), .visable(vis[3]), .load_pos(lp[3]),
    .load_att(la[3]), .sprite_sel(sel[3]), .busy(bsy[3]));

  // Inputs of a row are sampled at the next edge; expected values are the
  // outputs just after that edge. lp/la bit i belongs to instance di.
  typedef struct {
    logic       tick;
    logic       en;
    logic [3:0] lp;
    logic [3:0] la;
    int x0, y0, x1, y1, x2, y2, x3, s1, s2;
  } vec_t;

  vec_t tbl[23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    //          tick en  lp       la       x0 y0 x1   y1 x2   y2   x3 s1 s2
    tbl[0]  = '{1, 1, 4'b0000, 4'b0000,  0,  0, 606,  0, 608, 448, 0, 2, 2};
    tbl[1]  = '{0, 1, 4'b0111, 4'b0000,  2,  2, 608,  2, 608, 448, 0, 2, 2};
    tbl[2]  = '{1, 1, 4'b0000, 4'b0110,  2,  2, 608,  2, 608, 448, 0, 3, 3};
    tbl[3]  = '{0, 1, 4'b0000, 4'b0000,  2,  2, 608,  2, 608, 448, 0, 3, 3};
    tbl[4]  = '{1, 1, 4'b0000, 4'b0000,  2,  2, 608,  2, 608, 448, 0, 3, 3};
    tbl[5]  = '{1, 1, 4'b1111, 4'b0000,  4,  4, 606,  4, 606, 446, 2, 3, 3};
    tbl[6]  = '{0, 1, 4'b0000, 4'b0000,  4,  4, 606,  4, 606, 446, 2, 3, 3};
    tbl[7]  = '{0, 1, 4'b0000, 4'b0000,  4,  4, 606,  4, 606, 446, 2, 3, 3};
    tbl[8]  = '{1, 0, 4'b0000, 4'b0000,  4,  4, 606,  4, 606, 446, 2, 3, 3};
    tbl[9]  = '{0, 0, 4'b0000, 4'b0000,  4,  4, 606,  4, 606, 446, 2, 3, 3};
    tbl[10] = '{1, 0, 4'b0000, 4'b0000,  4,  4, 606,  4, 606, 446, 2, 3, 3};
    tbl[11] = '{0, 1, 4'b0000, 4'b0000,  4,  4, 606,  4, 606, 446, 2, 3, 3};
    tbl[12] = '{1, 1, 4'b0000, 4'b0000,  4,  4, 606,  4, 606, 446, 2, 3, 3};
    tbl[13] = '{0, 1, 4'b0111, 4'b0000,  6,  6, 604,  6, 604, 444, 2, 3, 3};
    tbl[14] = '{0, 1, 4'b0000, 4'b0000,  6,  6, 604,  6, 604, 444, 2, 3, 3};
    tbl[15] = '{0, 1, 4'b0000, 4'b0000,  6,  6, 604,  6, 604, 444, 2, 3, 3};
    tbl[16] = '{1, 1, 4'b0000, 4'b0000,  6,  6, 604,  6, 604, 444, 2, 3, 3};
    tbl[17] = '{0, 1, 4'b0111, 4'b0000,  8,  8, 602,  8, 602, 442, 2, 3, 3};
    tbl[18] = '{0, 1, 4'b0000, 4'b0000,  8,  8, 602,  8, 602, 442, 2, 3, 3};
    tbl[19] = '{0, 1, 4'b0000, 4'b0000,  8,  8, 602,  8, 602, 442, 2, 3, 3};
    tbl[20] = '{1, 1, 4'b0000, 4'b0000,  8,  8, 602,  8, 602, 442, 2, 3, 3};
    tbl[21] = '{0, 1, 4'b1111, 4'b0000, 10, 10, 600, 10, 600, 440, 4, 3, 3};
    tbl[22] = '{0, 1, 4'b0000, 4'b0000, 10, 10, 600, 10, 600, 440, 4, 3, 3};

    // Reset state.
    rst = 1'b1; enable = 1'b1; frame_tick = 1'b0;
    step(); step();
    chk("rst lp0",   int'(lp[0]),  0);
    chk("rst la0",   int'(la[0]),  0);
    chk("rst vis0",  int'(vis[0]), 0);
    chk("rst sel0",  int'(sel[0]), 2);
    chk("rst x1",    int'(xo[1]),  606);
    chk("rst busy0", int'(bsy[0]), 1);

    // INIT strobe right after reset is released.
    rst = 1'b0;
    step();
    chk("init lp0",  int'(lp[0]),  1);
    chk("init la0",  int'(la[0]),  1);
    chk("init vis0", int'(vis[0]), 1);
    chk("init sel0", int'(sel[0]), 2);
    chk("init x0",   int'(xo[0]),  0);
    chk("init y0",   int'(yo[0]),  0);
    chk("init vis2", int'(vis[2]), 1);
    step();
    chk("idle lp0",   int'(lp[0]),  0);
    chk("idle la0",   int'(la[0]),  0);
    chk("idle busy0", int'(bsy[0]), 0);

    // Table-driven run: moves, bounces, corner hit, dropped ticks,
    // enable gating and frame division.
    for (int i = 0; i < 23; i++) begin
      frame_tick = tbl[i].tick;
      enable     = tbl[i].en;
      step();
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("r%0d lp%0d", i, j), int'(lp[j]), int'(tbl[i].lp[j]));
        chk($sformatf("r%0d la%0d", i, j), int'(la[j]), int'(tbl[i].la[j]));
      end
      chk($sformatf("r%0d x0", i),   int'(xo[0]),  tbl[i].x0);
      chk($sformatf("r%0d y0", i),   int'(yo[0]),  tbl[i].y0);
      chk($sformatf("r%0d x1", i),   int'(xo[1]),  tbl[i].x1);
      chk($sformatf("r%0d y1", i),   int'(yo[1]),  tbl[i].y1);
      chk($sformatf("r%0d x2", i),   int'(xo[2]),  tbl[i].x2);
      chk($sformatf("r%0d y2", i),   int'(yo[2]),  tbl[i].y2);
      chk($sformatf("r%0d x3", i),   int'(xo[3]),  tbl[i].x3);
      chk($sformatf("r%0d sel1", i), int'(sel[1]), tbl[i].s1);
      chk($sformatf("r%0d sel2", i), int'(sel[2]), tbl[i].s2);
    end
    frame_tick = 1'b0;
    enable     = 1'b1;

    // Reset during the LOAD_POS cycle of a bouncing move on d1.
    rst = 1'b1; step();
    rst = 1'b0; step();          // INIT strobe
    step();                      // WAIT
    frame_tick = 1'b1; step();   // MOVE
    frame_tick = 1'b0;
    chk("seq busy0 move", int'(bsy[0]), 1);
    chk("seq lp1 move",   int'(lp[1]),  0);
    step();                      // LOAD_POS
    chk("seq lp1 pos", int'(lp[1]), 1);
    chk("seq x1 pos",  int'(xo[1]), 608);
    rst = 1'b1; step();
    chk("seq rst la1",   int'(la[1]),  0);
    chk("seq rst lp1",   int'(lp[1]),  0);
    chk("seq rst x1",    int'(xo[1]),  606);
    chk("seq rst vis1",  int'(vis[1]), 0);
    chk("seq rst sel1",  int'(sel[1]), 2);
    rst = 1'b0; step();
    chk("seq reinit lp1",  int'(lp[1]),  1);
    chk("seq reinit la1",  int'(la[1]),  1);
    chk("seq reinit vis1", int'(vis[1]), 1);
    chk("seq reinit x1",   int'(xo[1]),  606);
    step();
    chk("seq after la1",  int'(la[1]),  0);
    chk("seq after sel1", int'(sel[1]), 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
